frustum_param_sequencer: RTL
============================

Name: frustum_param_sequencer

Overview:
- Computes, once per frame, the camera position and four ground-plane frustum corners (near/far × left/right) that the perspective map renderer interpolates per pixel.
- Replaces per-pixel combinational trig/multiply logic with one shared cos/sin lookup port and one shared 16×16 multiplier, sequenced by an FSM.
- Runs during vertical blanking and commits all results atomically, so the renderer sees constant parameters for a whole frame.

Parameters:
- HALF_FOV, 55: half field of view, degrees.
- BALL_DEPTH, 7: camera distance behind the ball, map units.
- NEAR_MAG, 5: near-plane ray length; equals (3<<8)/146.
- FAR_MAG, 110: far-plane ray length; equals (63<<8)/146.
- LUT_LATENCY, 1: cycles from lut_angle_out to valid lut_* inputs (at least 1).

Ports:
- pixel_clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- frame_start_in  in  1  single-cycle pulse at start of vblank.
- ballx_in  in  16  ball x; bits [15:5] used.
- bally_in  in  16  ball y; bits [15:5] used.
- angle_in  in  16  heading in degrees; legal range 0..359.
- lut_angle_out  out  16  angle to the shared cos_sin_lookup.
- lut_cos_abs_in  in  16  |cos|, 8.8 fixed point.
- lut_sin_abs_in  in  16  |sin|, 8.8 fixed point.
- lut_cos_sign_in  in  1  1 = negative.
- lut_sin_sign_in  in  1  1 = negative.
- cam_x_out, cam_y_out  out  16 each  committed camera position.
- nearl_x_out, nearl_y_out, nearr_x_out, nearr_y_out  out  16 each  committed near corners.
- farl_x_out, farl_y_out, farr_x_out, farr_y_out  out  16 each  committed far corners.
- busy_out  out  1  sequence in progress.
- params_valid_out  out  1  one-cycle pulse on commit.
- overrun_out  out  1  sticky: frame_start_in arrived while busy.
- angle_err_out  out  1  sticky: latched angle was ≥360.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE; every output is 0, including lut_angle_out and all committed registers.
- IDLE, frame_start_in=1: latch ballx_in, bally_in, angle_in; go to LUT.
  - bx = ballx_in[15:5]+720, by = bally_in[15:5]+720, zero-extended to 16 bits.
  - If latched angle ≥360: use 0 and set angle_err_out.
- LUT: drive lut_angle_out with a, ra, la on three consecutive cycles.
  - ra = a≥HALF_FOV ? a−HALF_FOV : a+360−HALF_FOV.
  - la = a<360−HALF_FOV ? a+HALF_FOV : a+HALF_FOV−360.
  - Capture each result LUT_LATENCY cycles after it is issued. lut_angle_out holds the last issued value afterwards.
- MUL: one product per cycle through the single multiplier; each product is registered before use (1-stage pipe). Order:
  1. BALL_DEPTH·cos(a)
  2. BALL_DEPTH·sin(a)
  3. FAR_MAG·cos(la), FAR_MAG·sin(la), FAR_MAG·cos(ra), FAR_MAG·sin(ra)
  4. NEAR_MAG, same four.
  - Each term t = (32-bit product)>>5, truncated to 16 bits. All adds and subtracts wrap modulo 2^16.
  - cam_x = bx + t if cos sign 0, else bx − t.
  - cam_y = by − t if sin sign 0, else by + t.
  - Corner x = cam_x − t if cos sign 0, else cam_x + t.
  - Corner y = cam_y + t if sin sign 0, else cam_y − t.
- COMMIT: copy all ten shadow values to the outputs in the same cycle; pulse params_valid_out; return to IDLE.
- Latency: params_valid_out rises exactly 15+LUT_LATENCY cycles after the cycle frame_start_in is sampled (16 at default). busy_out is high from the next cycle through the COMMIT cycle inclusive.
- frame_start_in while busy or in COMMIT: ignored and sets overrun_out. The in-progress sequence is unaffected.
- Committed outputs change only on COMMIT or reset. Reset mid-sequence discards partial results.
- Ball and angle inputs are ignored except on the latch cycle.

Test Plan:
- Reset: hold rst_n_in=0 mid-sequence → all outputs 0 immediately; after release no params_valid_out without a new frame_start_in.
- Bench LUT returns round(256·cos/sin): ballx=bally=0, angle=0, pulse → params_valid_out at cycle 16 with:
  - cam=(776,720)
  - farl=(271,1441), farr=(271,0xFFFF)
  - nearl=(754,752), nearr=(754,688)
- Angle wrap: angle=10 → lut_angle_out sequence 10, 315, 65. angle=340 → 340, 285, 35.
- Overrun: second frame_start_in 5 cycles after the first → overrun_out=1, one params_valid_out only, results from the first latch.
- Bad angle: angle=400 → angle_err_out=1; outputs equal the angle=0 results.
- Inputs changed during busy (ballx=0xFFFF) → committed values match the latched inputs; outputs stay stable between commits.

Source files
------------

// File: rtl/frustum_param_sequencer.sv
// Per-frame camera position and ground-plane frustum corner generator. One shared
// cos/sin lookup and one 16x16 multiplier are sequenced during vertical blanking.
module frustum_param_sequencer #(
    parameter int unsigned HALF_FOV    = 55,
    parameter int unsigned BALL_DEPTH  = 7,
    parameter int unsigned NEAR_MAG    = 5,
    parameter int unsigned FAR_MAG     = 110,
    parameter int unsigned LUT_LATENCY = 1
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        frame_start_in,
    input  logic [15:0] ballx_in,
    input  logic [15:0] bally_in,
    input  logic [15:0] angle_in,
    output logic [15:0] lut_angle_out,
    input  logic [15:0] lut_cos_abs_in,
    input  logic [15:0] lut_sin_abs_in,
    input  logic        lut_cos_sign_in,
    input  logic        lut_sin_sign_in,
    output logic [15:0] cam_x_out,
    output logic [15:0] cam_y_out,
    output logic [15:0] nearl_x_out,
    output logic [15:0] nearl_y_out,
    output logic [15:0] nearr_x_out,
    output logic [15:0] nearr_y_out,
    output logic [15:0] farl_x_out,
    output logic [15:0] farl_y_out,
    output logic [15:0] farr_x_out,
    output logic [15:0] farr_y_out,
    output logic        busy_out,
    output logic        params_valid_out,
    output logic        overrun_out,
    output logic        angle_err_out
);
    localparam int unsigned W         = 16;
    localparam int unsigned CW        = 8;
    localparam int unsigned N_TERMS   = 10;
    localparam int unsigned CAP_A     = 1 + LUT_LATENCY;
    localparam int unsigned CAP_R     = 2 + LUT_LATENCY;
    localparam int unsigned CAP_L     = 3 + LUT_LATENCY;
    localparam int unsigned MUL_FIRST = 3 + LUT_LATENCY;
    localparam int unsigned ACC_FIRST = 4 + LUT_LATENCY;
    localparam int unsigned COMMIT_AT = 14 + LUT_LATENCY;

    typedef enum logic [1:0] {S_IDLE, S_LUT, S_MUL, S_COMMIT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cyc;
    logic [W-1:0]  ang, bx, by, term;
    logic [W-1:0]  cap_abs [6];
    logic [5:0]    cap_sgn;
    logic [W-1:0]  sh [N_TERMS];

    logic          start_c, mul_en_c, acc_en_c, add_c;
    logic [3:0]    mul_idx_c, acc_idx_c;
    logic [2:0]    mul_sel_c, acc_sel_c;
    logic [W-1:0]  ang_fix_c, ra_c, la_c, mul_k_c, base_c, acc_val_c;
    logic [2*W-1:0] prod_c;
    logic          unused_bits;

    assign unused_bits = ^{ballx_in[4:0], bally_in[4:0]};

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (frame_start_in) state_nx = S_LUT;
            S_LUT:    if (cyc == CW'(CAP_L)) state_nx = S_MUL;
            S_MUL:    if (cyc == CW'(COMMIT_AT)) state_nx = S_COMMIT;
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Angle fixup and the right/left ray angles, wrapped into 0..359
    always_comb begin
        start_c   = (state == S_IDLE) && frame_start_in;
        ang_fix_c = (angle_in >= W'(360)) ? '0 : angle_in;
        ra_c = (ang >= W'(HALF_FOV)) ? ang - W'(HALF_FOV) : ang + W'(360 - HALF_FOV);
        la_c = (ang < W'(360 - HALF_FOV)) ? ang + W'(HALF_FOV) : ang - W'(360 - HALF_FOV);
    end

    // Operand select for the shared multiplier; products 6..9 reuse the far operands
    always_comb begin
        mul_en_c  = (state != S_IDLE) && (cyc >= CW'(MUL_FIRST))
                    && (cyc < CW'(MUL_FIRST + N_TERMS));
        mul_idx_c = 4'(cyc - CW'(MUL_FIRST));
        mul_sel_c = 3'((mul_idx_c >= 4'd6) ? mul_idx_c - 4'd4 : mul_idx_c);
        if (mul_idx_c < 4'd2)      mul_k_c = W'(BALL_DEPTH);
        else if (mul_idx_c < 4'd6) mul_k_c = W'(FAR_MAG);
        else                       mul_k_c = W'(NEAR_MAG);
        prod_c = 32'(mul_k_c) * 32'(cap_abs[mul_sel_c]);
    end

    // Accumulate: camera offsets from the ball, corners offset from the camera
    always_comb begin
        acc_en_c  = (state != S_IDLE) && (cyc >= CW'(ACC_FIRST))
                    && (cyc < CW'(ACC_FIRST + N_TERMS));
        acc_idx_c = 4'(cyc - CW'(ACC_FIRST));
        acc_sel_c = 3'((acc_idx_c >= 4'd6) ? acc_idx_c - 4'd4 : acc_idx_c);
        base_c    = acc_idx_c[0] ? sh[1] : sh[0];
        if (acc_idx_c < 4'd2) base_c = acc_idx_c[0] ? by : bx;
        // x terms add on a positive sign at the camera and subtract at corners; y is the mirror
        add_c     = ~acc_idx_c[0] ^ cap_sgn[acc_sel_c] ^ (acc_idx_c >= 4'd2);
        acc_val_c = add_c ? base_c + term : base_c - term;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cyc <= '0; ang <= '0; bx <= '0; by <= '0; term <= '0; cap_sgn <= '0;
            for (int i = 0; i < 6; i++) cap_abs[i] <= '0;
            for (int i = 0; i < N_TERMS; i++) sh[i] <= '0;
            lut_angle_out <= '0;
            cam_x_out <= '0;   cam_y_out <= '0;
            nearl_x_out <= '0; nearl_y_out <= '0; nearr_x_out <= '0; nearr_y_out <= '0;
            farl_x_out <= '0;  farl_y_out <= '0;  farr_x_out <= '0;  farr_y_out <= '0;
            busy_out <= 1'b0;  params_valid_out <= 1'b0;
            overrun_out <= 1'b0; angle_err_out <= 1'b0;
        end else begin
            busy_out         <= (state_nx != S_IDLE);
            params_valid_out <= (state_nx == S_COMMIT);
            if (frame_start_in && (state != S_IDLE)) overrun_out <= 1'b1;
            if (start_c) begin
                ang           <= ang_fix_c;
                bx            <= W'(ballx_in[15:5]) + W'(720);
                by            <= W'(bally_in[15:5]) + W'(720);
                lut_angle_out <= ang_fix_c;
                cyc           <= CW'(1);
                if (angle_in >= W'(360)) angle_err_out <= 1'b1;
            end else if (state != S_IDLE) begin
                cyc <= cyc + CW'(1);
                if (cyc == CW'(1)) lut_angle_out <= ra_c;
                if (cyc == CW'(2)) lut_angle_out <= la_c;
                if (cyc == CW'(CAP_A)) begin
                    cap_abs[0] <= lut_cos_abs_in; cap_abs[1] <= lut_sin_abs_in;
                    cap_sgn[1:0] <= {lut_sin_sign_in, lut_cos_sign_in};
                end
                if (cyc == CW'(CAP_R)) begin
                    cap_abs[4] <= lut_cos_abs_in; cap_abs[5] <= lut_sin_abs_in;
                    cap_sgn[5:4] <= {lut_sin_sign_in, lut_cos_sign_in};
                end
                if (cyc == CW'(CAP_L)) begin
                    cap_abs[2] <= lut_cos_abs_in; cap_abs[3] <= lut_sin_abs_in;
                    cap_sgn[3:2] <= {lut_sin_sign_in, lut_cos_sign_in};
                end
                if (mul_en_c) term <= W'(prod_c >> 5);
                if (acc_en_c) sh[acc_idx_c] <= acc_val_c;
                if ((state == S_MUL) && (state_nx == S_COMMIT)) begin
                    cam_x_out   <= sh[0]; cam_y_out   <= sh[1];
                    farl_x_out  <= sh[2]; farl_y_out  <= sh[3];
                    farr_x_out  <= sh[4]; farr_y_out  <= sh[5];
                    nearl_x_out <= sh[6]; nearl_y_out <= sh[7];
                    nearr_x_out <= sh[8]; nearr_y_out <= sh[9];
                end
            end
        end
    end
endmodule
